// File: rtl/hy_tick_irq_pkg.sv
// Shared definitions for the tick-to-interrupt block.
//   - handshake FSM state encoding (2'd3 is illegal and recovers to IDLE)
//   - default counter widths
package hy_tick_irq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ACKD = 2'd2;

    localparam int P_WIDTH_DEF = 4;
    localparam int T_WIDTH_DEF = 16;

endpackage

// File: rtl/hy_tick_irq_sat_cnt.sv
// Saturating up/down counter with synchronous clear.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   clr_i       synchronous clear to zero (beats inc/dec)
//   inc_i       count up by one, held at all-ones when saturated
//   dec_i       count down by one, held at zero when empty
//   cnt_o       registered count
//   ovf_o       strobe: an increment was lost to saturation this cycle
module hy_sat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         ovf_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         full, empty;

    assign full  = (cnt_q == {W{1'b1}});
    assign empty = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && !full) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && !empty) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Simultaneous inc and dec cancel, so only an unmatched increment can overflow.
    assign ovf_o = inc_i && !dec_i && full && !clr_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hy_tick_irq.sv
// Converts timer expiry cycles into queued events and signals them to the
// host over a 4-phase req/ack interrupt handshake.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   tick_in     expiry level; every cycle sampled high is one event
//   en          event enable; events while low are dropped entirely
//   clr         clears pending, overrun and the handshake (ev_total kept)
//   irq_ack     host acknowledge
//   irq_req     registered interrupt request, high only in REQ
//   pending     saturating count of unacknowledged events
//   overrun     sticky flag: an event was lost to saturation
//   ev_total    wrapping lifetime count of accepted events
module hy_tick_irq
    import hy_tick_irq_pkg::*;
#(
    parameter int P_WIDTH = P_WIDTH_DEF,
    parameter int T_WIDTH = T_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_in,
    input  logic               en,
    input  logic               clr,
    input  logic               irq_ack,
    output logic               irq_req,
    output logic [P_WIDTH-1:0] pending,
    output logic               overrun,
    output logic [T_WIDTH-1:0] ev_total
);

    logic [1:0]         state_q, state_d;
    logic               irq_req_q;
    logic               overrun_q;
    logic [T_WIDTH-1:0] ev_total_q;
    logic               accept, consume, ovf;
    logic [P_WIDTH-1:0] pend_cnt;

    assign accept  = tick_in && en;
    // Consume is the REQ->ACKD transition; REQ is only reachable with pending>=1.
    assign consume = (state_q == ST_REQ) && irq_ack && !clr;

    hy_sat_cnt #(.W(P_WIDTH)) u_pend (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .inc_i (accept),
        .dec_i (consume),
        .cnt_o (pend_cnt),
        .ovf_o (ovf)
    );

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                // Entry uses registered pending: one cycle after it turns nonzero.
                ST_IDLE: if (pend_cnt != '0 && !irq_ack) state_d = ST_REQ;
                ST_REQ:  if (irq_ack)                    state_d = ST_ACKD;
                ST_ACKD: if (!irq_ack)                   state_d = ST_IDLE;
                default:                                 state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            irq_req_q  <= 1'b0;
            overrun_q  <= 1'b0;
            ev_total_q <= '0;
        end else begin
            state_q   <= state_d;
            irq_req_q <= (state_d == ST_REQ);
            if (clr) begin
                overrun_q <= 1'b0;
            end else if (ovf) begin
                overrun_q <= 1'b1;
            end
            // Lifetime count ignores clr; only reset zeroes it.
            if (accept) begin
                ev_total_q <= ev_total_q + 1'b1;
            end
        end
    end

    assign irq_req  = irq_req_q;
    assign pending  = pend_cnt;
    assign overrun  = overrun_q;
    assign ev_total = ev_total_q;

endmodule

// File: tb/tb_hy_tick_irq.sv
module tb_hy_tick_irq;

    logic        clk = 1'b0;
    logic        rst_n, tick_in, en, clr, irq_ack;
    logic        irq_req, overrun;
    logic [3:0]  pending;
    logic [15:0] ev_total;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hy_tick_irq #(.P_WIDTH(4), .T_WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_in  (tick_in),
        .en       (en),
        .clr      (clr),
        .irq_ack  (irq_ack),
        .irq_req  (irq_req),
        .pending  (pending),
        .overrun  (overrun),
        .ev_total (ev_total)
    );

    typedef struct {
        logic        rst_n, en, tick, clr, ack;
        logic        req;
        logic [3:0]  pend;
        logic        ovr;
        logic [15:0] tot;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(logic r, logic e, logic t, logic c, logic a,
                                logic q, logic [3:0] p, logic o, logic [15:0] tt);
        vec_t v;
        v.rst_n = r; v.en = e; v.tick = t; v.clr = c; v.ack = a;
        v.req = q; v.pend = p; v.ovr = o; v.tot = tt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic e, input logic t, input logic c, input logic a);
        @(negedge clk);
        rst_n = r; en = e; tick_in = t; clr = c; irq_ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic q, input logic [3:0] p,
                           input logic o, input logic [15:0] tt);
        chk({name, ".irq_req"},  {31'd0, irq_req}, {31'd0, q});
        chk({name, ".pending"},  {28'd0, pending}, {28'd0, p});
        chk({name, ".overrun"},  {31'd0, overrun}, {31'd0, o});
        chk({name, ".ev_total"}, {16'd0, ev_total}, {16'd0, tt});
    endtask

    initial begin
        int n;
        rst_n = 1'b0; en = 1'b0; tick_in = 1'b0; clr = 1'b0; irq_ack = 1'b0;

        //             rst en tk clr ack | req pend ovr tot
        vecs[0]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0);  // reset
        vecs[1]  = mk(1, 1, 1, 0, 0,  0, 1, 0, 1);  // single tick accepted
        vecs[2]  = mk(1, 1, 0, 0, 0,  1, 1, 0, 1);  // IDLE->REQ, 2 edges after tick
        vecs[3]  = mk(1, 1, 0, 0, 1,  0, 0, 0, 1);  // ack: consume, ACKD
        vecs[4]  = mk(1, 1, 0, 0, 0,  0, 0, 0, 1);  // ack low: IDLE
        vecs[5]  = mk(1, 1, 0, 0, 0,  0, 0, 0, 1);
        vecs[6]  = mk(1, 0, 1, 0, 0,  0, 0, 0, 1);  // en=0 drops ticks
        vecs[7]  = mk(1, 0, 1, 0, 0,  0, 0, 0, 1);
        vecs[8]  = mk(1, 0, 1, 0, 0,  0, 0, 0, 1);
        vecs[9]  = mk(1, 1, 1, 0, 0,  0, 1, 0, 2);  // build pending=3
        vecs[10] = mk(1, 1, 1, 0, 0,  1, 2, 0, 3);
        vecs[11] = mk(1, 1, 1, 0, 0,  1, 3, 0, 4);
        vecs[12] = mk(1, 1, 1, 0, 1,  0, 3, 0, 5);  // tick + consume: pending held
        vecs[13] = mk(1, 1, 0, 0, 1,  0, 3, 0, 5);  // ack held: stay ACKD
        vecs[14] = mk(1, 1, 0, 0, 0,  0, 3, 0, 5);  // release ack: IDLE
        vecs[15] = mk(1, 1, 0, 0, 0,  1, 3, 0, 5);  // req re-rises 2 edges after release
        vecs[16] = mk(1, 1, 1, 1, 0,  0, 0, 0, 6);  // clr with tick: only ev_total counts
        vecs[17] = mk(1, 1, 0, 0, 0,  0, 0, 0, 6);
        vecs[18] = mk(1, 1, 1, 0, 1,  0, 1, 0, 7);  // ack high in IDLE
        vecs[19] = mk(1, 1, 0, 0, 1,  0, 1, 0, 7);  // violation: stays IDLE
        vecs[20] = mk(1, 1, 0, 0, 0,  1, 1, 0, 7);
        vecs[21] = mk(1, 1, 0, 0, 1,  0, 0, 0, 7);  // ACKD
        vecs[22] = mk(0, 1, 1, 0, 1,  0, 0, 0, 0);  // reset mid-ACKD wins over tick
        vecs[23] = mk(1, 0, 0, 0, 1,  0, 0, 0, 0);  // out of reset, ack high: IDLE

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].en, vecs[i].tick, vecs[i].clr, vecs[i].ack);
            chk_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].pend, vecs[i].ovr, vecs[i].tot);
        end

        // en=0 after reset: five pulses leave everything at zero.
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 0, 0);
            step(1, 0, 0, 0, 0);
        end
        chk_all("en_off", 0, 0, 0, 0);

        // Saturation: 20 consecutive ticks, host silent.
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 1, 0, 0);
            if (i == 14) chk_all("sat15", 1, 15, 0, 15);
        end
        chk_all("sat20", 1, 15, 1, 20);

        // Drain 15 -> 7 via 8 handshakes, host answering within a bounded wait.
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (!irq_req && n < 10) begin
                step(1, 1, 0, 0, 0);
                n++;
            end
            chk($sformatf("drain%0d.req_seen", k), {31'd0, irq_req}, 32'd1);
            step(1, 1, 0, 0, 1);
            step(1, 1, 0, 0, 0);
        end
        chk_all("drained", 0, 7, 1, 20);

        step(1, 1, 0, 1, 0);
        chk_all("clr7", 0, 0, 0, 20);

        // Saturated queue with a simultaneous consume: no overrun.
        for (int i = 0; i < 15; i++) step(1, 1, 1, 0, 0);
        chk_all("sat_again", 1, 15, 0, 35);
        step(1, 1, 1, 0, 1);
        chk_all("sat_consume", 0, 15, 0, 36);
        step(1, 1, 0, 0, 0);

        // Lifetime counter wrap.
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 65535; i++) step(1, 1, 1, 0, 0);
        chk("wrap.pre", {16'd0, ev_total}, 32'h0000_FFFF);
        chk("wrap.pre_ovr", {31'd0, overrun}, 32'd1);
        step(1, 1, 0, 1, 0);
        chk_all("wrap.clr", 0, 0, 0, 16'hFFFF);
        step(1, 1, 1, 0, 0);
        chk_all("wrap", 0, 1, 0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
